// File: rtl/fpu_add_seq.sv
// fpu_add_seq: multi-cycle binary16 adder, ALIGN -> ADD -> NORM behind valid/ready handshakes.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fpu_add_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   Asem,
  input  logic [EXP_W+MAN_W:0]   Bsem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Rsem
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // hidden + fraction + G,R,S
  localparam int EW = EXP_W + 2;   // exponent with sign/overflow headroom
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state;

  logic [W-1:0]     a_r, b_r, spec_v;
  logic             spec_f, sx, sy, rs;
  logic [EXP_W-1:0] ex;
  logic [SW-1:0]    mx, my;
  logic [SW:0]      sum;

  assign in_ready = (state == IDLE);

  // ALIGN: order by magnitude, align the smaller significand, flag specials
  logic             swap, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, spec_c;
  logic [W-1:0]     xo, yo, spec_c_v;
  logic [EXP_W-1:0] dexp;
  logic [SW-1:0]    ysig, ysh, ymask, yalign;

  assign swap   = b_r[W-2:0] > a_r[W-2:0];
  assign xo     = swap ? b_r : a_r;
  assign yo     = swap ? a_r : b_r;
  assign dexp   = xo[W-2:MAN_W] - yo[W-2:MAN_W];
  assign ysig   = {1'b1, yo[MAN_W-1:0], 3'b000};
  assign a_nan  = (&a_r[W-2:MAN_W]) &&  (|a_r[MAN_W-1:0]);
  assign b_nan  = (&b_r[W-2:MAN_W]) &&  (|b_r[MAN_W-1:0]);
  assign a_inf  = (&a_r[W-2:MAN_W]) && !(|a_r[MAN_W-1:0]);
  assign b_inf  = (&b_r[W-2:MAN_W]) && !(|b_r[MAN_W-1:0]);
  assign a_zero = (a_r[W-2:MAN_W] == '0);
  assign b_zero = (b_r[W-2:MAN_W] == '0);

  always_comb begin
    ysh    = ysig >> dexp;
    ymask  = ~({SW{1'b1}} << dexp);
    yalign = {ysh[SW-1:1], ysh[0] | (|(ysig & ymask))};
    if (int'(dexp) >= SW - 1) yalign = {{(SW-1){1'b0}}, 1'b1};
  end

  always_comb begin
    spec_c   = 1'b1;
    spec_c_v = '0;
    if (a_nan || b_nan)                          spec_c_v = QNAN;
    else if (a_inf && b_inf && a_r[W-1] != b_r[W-1]) spec_c_v = QNAN;
    else if (a_inf)                              spec_c_v = a_r;
    else if (b_inf)                              spec_c_v = b_r;
    else if (a_zero)                             spec_c_v = b_r;
    else if (b_zero)                             spec_c_v = a_r;
    else                                         spec_c   = 1'b0;
  end

  // NORM: normalise, round, pack
  logic [EW-1:0]    lz, ne;
  logic [SW-1:0]    nm;
  logic [MAN_W+1:0] rm;
  logic [W-1:0]     res;
  logic             unused_bits;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++)
      if (sum[i]) lz = EW'(SW - 1 - i);
    if (sum[SW]) begin
      nm = {sum[SW:2], sum[1] | sum[0]};
      ne = {2'b00, ex} + EW'(1);
    end else begin
      nm = sum[SW-1:0] << lz;
      ne = {2'b00, ex} - lz;
    end
    rm = {1'b0, nm[SW-1:3]};
`ifdef ROUND_NEAREST_EN
    if (nm[2] && (nm[1] || nm[0] || nm[3])) rm = rm + 1'b1;
`endif
    if (rm[MAN_W+1]) begin
      rm = rm >> 1;
      ne = ne + EW'(1);
    end
    if (spec_f)                    res = spec_v;
    else if (sum == '0)            res = '0;
    else if (ne[EW-1] || ne == '0) res = '0;
    else if (ne >= {2'b00, EMAX})  res = {rs, EMAX, {MAN_W{1'b0}}};
    else                           res = {rs, ne[EXP_W-1:0], rm[MAN_W-1:0]};
  end

  assign unused_bits = ^{rm[MAN_W], nm[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Rsem      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      spec_v    <= '0;
      spec_f    <= 1'b0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      rs        <= 1'b0;
      ex        <= '0;
      mx        <= '0;
      my        <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= Asem;
          b_r   <= Bsem;
          state <= ALIGN;
        end
        ALIGN: begin
          sx     <= xo[W-1];
          sy     <= yo[W-1];
          ex     <= xo[W-2:MAN_W];
          mx     <= {1'b1, xo[MAN_W-1:0], 3'b000};
          my     <= yalign;
          spec_f <= spec_c;
          spec_v <= spec_c_v;
          state  <= ADD;
        end
        ADD: begin
          sum   <= (sx == sy) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
          rs    <= sx;
          state <= NORM;
        end
        NORM: begin
          Rsem      <= res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_add_seq.sv
// Bench for fpu_add_seq: directed cases, randomized ops against an exact-arithmetic model,
// backpressure and mid-operation reset.
module tb_fpu_add_seq;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] Asem = '0, Bsem = '0, Rsem;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  fpu_add_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Asem(Asem), .Bsem(Bsem), .out_valid(out_valid), .out_ready(out_ready), .Rsem(Rsem)
  );

  // Reference: classify specials, otherwise add exactly in units of 2^-24 and re-encode.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, e, p;
    longint va, vb, s, mag, m, rem, half;
    bit     neg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7E00;
    if (ea == 31 && eb == 31) return (a[15] == b[15]) ? a : 16'h7E00;
    if (ea == 31) return a;
    if (eb == 31) return b;
    if (ea == 0) return b;
    if (eb == 0) return a;
    va = longint'({1'b1, a[9:0]}) << (ea - 1);
    vb = longint'({1'b1, b[9:0]}) << (eb - 1);
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    s = va + vb;
    if (s == 0) return 16'h0000;
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (e <= 0) return 16'h0000;
    m   = mag >> (e - 1);
    rem = mag - (m << (e - 1));
`ifdef ROUND_NEAREST_EN
    if (e >= 2) begin
      half = longint'(1) << (e - 2);
      if (rem > half || (rem == half && m[0])) m = m + 1;
    end
    if (m == 2048) begin m = 1024; e = e + 1; end
`else
    half = rem;
`endif
    if (e >= 31) return {neg, 5'h1F, 10'h000};
    return {neg, 5'(e), m[9:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    int          k;
    v = 16'($urandom);
    k = $urandom_range(0, 19);
    if (k == 0) v[14:10] = 5'd0;
    else if (k == 1) begin
      v[14:10] = 5'd31;
      if ($urandom_range(0, 1) == 0) v[9:0] = '0;
    end else if (k < 5) v[14:10] = 5'(28 + $urandom_range(0, 2));
    return v;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    ok = in_ready;
    in_valid = 1'b1; Asem = a; Bsem = b;
    @(posedge clk); #1;
    in_valid = 1'b0; Asem = 16'($urandom); Bsem = 16'($urandom);
  endtask

  // lat = number of rising edges after accept until one samples out_valid high
  task automatic collect(output logic [15:0] r, output int lat);
    logic v;
    lat = 0;
    r   = 'x;
    do begin
      @(negedge clk); v = out_valid; r = Rsem;
      @(posedge clk); lat++;
    end while (!v && lat < 20);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (Rsem !== 16'h0000) begin errors++; $display("FAIL reset_rsem got %h want 0000", Rsem); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [7] = '{16'hCA60, 16'h4400, 16'hC000, 16'h3C01, 16'h7BFF, 16'h7C00, 16'h7E00};
    logic [15:0] tb [7] = '{16'hC460, 16'hC400, 16'h0000, 16'h1000, 16'h7BFF, 16'hFC00, 16'h3C00};
`ifdef ROUND_NEAREST_EN
    logic [15:0] te [7] = '{16'hCC48, 16'h0000, 16'hC000, 16'h3C02, 16'h7C00, 16'h7E00, 16'h7E00};
`else
    logic [15:0] te [7] = '{16'hCC48, 16'h0000, 16'hC000, 16'h3C01, 16'h7C00, 16'h7E00, 16'h7E00};
`endif
    logic [15:0] r;
    int          lat;
    bit          ok;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(ta[i], tb[i], ok);
      collect(r, lat);
      checks++;
      if (!ok || r !== te[i]) begin
        errors++; $display("FAIL directed[%0d] %h+%h got %h want %h", i, ta[i], tb[i], r, te[i]);
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, exp_r;
    int          lat;
    bit          ok;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = rand_op();
      b = rand_op();
      case ($urandom_range(0, 3))
        0: b = {~a[15], a[14:4], 4'($urandom)};                       // near cancellation
        1: b[14:10] = 5'(int'(a[14:10]) ^ $urandom_range(0, 3));     // close exponents
        default: ;
      endcase
      exp_r = ref_add(a, b);
      send(a, b, ok);
      collect(r, lat);
      checks++;
      if (!ok || r !== exp_r || lat !== 4) begin
        errors++; $display("FAIL random[%0d] %h+%h got %h lat %0d want %h lat 4", i, a, b, r, lat, exp_r);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b, r, exp_r;
    int          lat;
    bit          ok;
    a = 16'h4248; b = 16'hBC00;
    exp_r = ref_add(a, b);
    out_ready = 1'b0;
    send(a, b, ok);
    collect(r, lat);
    checks++;
    if (!ok || r !== exp_r || lat !== 4) begin
      errors++; $display("FAIL hold_first got %h lat %0d want %h lat 4", r, lat, exp_r);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; Asem = 16'($urandom); Bsem = 16'($urandom);
      checks++;
      if (out_valid !== 1'b1 || Rsem !== exp_r || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d] valid %b rsem %h in_ready %b want 1 %h 0", i, out_valid, Rsem, in_ready, exp_r);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
    a = rand_op(); b = rand_op();
    exp_r = ref_add(a, b);
    send(a, b, ok);
    collect(r, lat);
    checks++;
    if (!ok || r !== exp_r || lat !== 4) begin
      errors++; $display("FAIL hold_second %h+%h got %h lat %0d want %h lat 4", a, b, r, lat, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r, exp_r;
    int          lat;
    bit          ok, stale;
    out_ready = 1'b1;
    send(16'h3C00, 16'h4000, ok);    // now in ALIGN
    @(posedge clk); #1;              // now in ADD
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Rsem !== 16'h0000) begin
      errors++; $display("FAIL midreset out_valid %b in_ready %b rsem %h want 0 1 0000", out_valid, in_ready, Rsem);
    end
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL midreset_stale got out_valid 1 want 0"); end
    exp_r = ref_add(16'h4500, 16'hC100);
    send(16'h4500, 16'hC100, ok);
    collect(r, lat);
    checks++;
    if (!ok || r !== exp_r || lat !== 4) begin
      errors++; $display("FAIL midreset_after got %h lat %0d want %h lat 4", r, lat, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
